keypad_scan_ctrl: RTL and testbench
===================================

# keypad_scan_ctrl

Sequencer for the 4x4 matrix keypad. It drives the row lines one at a time and samples the column lines. Each press is debounced and resolved to the 4-bit active-low key code consumed by the keypad-to-ASCII converter. The code is then presented on a valid/ready handshake to the downstream character consumer (LCD/UART path).

## Interface
Parameters:
- SCAN_DIV, default 50000: clock cycles each row is driven (dwell); minimum 4.
- DEBOUNCE_CYC, default 500000: consecutive stable cycles required for press and for release; minimum 2.
- REPEAT_CYC, default 25000000: auto-repeat period; only used with KEYPAD_REPEAT_EN.

Ports:
- clk, input, 1: single system clock, rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- col_n, input, 4: keypad columns, active-low, asynchronous. Column 0 is the leftmost.
- row_n, output, 4: keypad rows, one-hot active-low. Row 0 is the top row.
- key_code, output, 4: converter encoding. Stable while key_valid=1.
- key_valid, output, 1: a key code is pending.
- key_ready, input, 1: the consumer accepts key_code.
- overrun, output, 1: one-cycle pulse when a detected key is dropped.

## Operation
- col_n passes through a 2-FF synchronizer. All decisions use the synchronized value.
- Key map, by row then col0..col3:
  - Row 0: 1=1110, 2=1101, 3=1100, A=0101
  - Row 1: 4=1011, 5=1010, 6=1001, B=0100
  - Row 2: 7=1000, 8=0111, 9=0110, C=0011
  - Row 3: *=0001, 0=1111, #=0000, D=0010
- State SCAN:
  - row_n rotates 1110→1101→1011→0111→1110, one step every SCAN_DIV cycles.
  - Columns are sampled only on the last dwell cycle.
  - If any sampled column is low, the lowest-index low column is latched, the row is frozen, and the FSM goes to DEBOUNCE.
  - Otherwise the row advances.
- State DEBOUNCE:
  - A counter increments each cycle the latched column is low.
  - If the latched column reads high, the FSM returns to SCAN and the row advances.
  - When the count reaches DEBOUNCE_CYC-1 with the column still low, the press is valid:
    - If key_valid=0, key_code is loaded and key_valid is set.
    - If key_valid=1, the press is dropped, the pending code is kept, and overrun pulses.
    - In both cases the FSM goes to HELD.
- State HELD:
  - The row stays frozen.
  - A release counter increments while the latched column is high and clears when it is low.
  - When the counter reaches DEBOUNCE_CYC-1, the FSM goes to SCAN and the row advances.
- Handshake:
  - A transfer occurs on a rising edge where key_valid=1 and key_ready=1; key_valid clears on that edge.
  - key_valid is independent of the FSM state. A pending code survives release and further scanning.
  - key_ready while key_valid=0 is ignored.
- Other columns in the frozen row, and all other rows, are ignored until the FSM returns to SCAN.

## Timing
- Reset values:
  - row_n=1110, key_code=1111, key_valid=0, overrun=0.
  - State=SCAN, all counters 0, synchronizer cleared.
- Reset is asynchronous at any point, including DEBOUNCE and HELD. The pending code is discarded and no overrun is generated.
- Column input to synchronized value: 2 cycles.
- key_valid rises exactly DEBOUNCE_CYC cycles after the edge that enters DEBOUNCE.
- The row is frozen from the DEBOUNCE entry edge until the HELD exit edge.
- The row change after a HELD exit or a DEBOUNCE abort takes effect on the same edge as the state change. Dwell restarts at 0.
- A new press and a transfer on the same edge: the transfer completes, and the new code loads with key_valid staying 1. No overrun.
- Dwell counter wraps at SCAN_DIV-1. Row index wraps from 3 to 0.

## Configuration
- KEYPAD_REPEAT_EN defined: a repeat counter runs in HELD, clearing on HELD entry and whenever the latched column reads high.
  - At REPEAT_CYC-1 it re-emits the latched code using the same rule as a new press (load if key_valid=0, else overrun), then restarts.
- KEYPAD_REPEAT_EN undefined:
  - No repeat counter exists.
  - Exactly one code is emitted per debounced press, however long the key is held.

## Test plan
Parameters for all scenarios: SCAN_DIV=4, DEBOUNCE_CYC=8, REPEAT_CYC=32.
- Idle after reset, no key:
  - row_n cycles 1110→1101→1011→0111 every 4 cycles.
  - key_valid stays 0 and overrun stays 0.
- Hold row 1/col 2 ("6"), key_ready=0:
  - row_n freezes at 1101.
  - key_valid rises 8 cycles after DEBOUNCE entry with key_code=1001.
  - Pulse key_ready: key_valid clears on that edge.
- Bounce row 3/col 1 ("0") low for 3 cycles, then high:
  - No key_valid; scanning resumes at row_n=1110.
  - A later stable press gives key_code=1111.
- Press "A" then, without accepting, release and press "#":
  - key_code stays 0101 and overrun pulses once.
  - After acceptance the next press "#" yields 0000.
- Row 0 col0 and col3 low together:
  - key_code=1110 ("1").
- KEYPAD_REPEAT_EN, hold "5" with key_ready=1:
  - First 1010, then 1010 again every 32 cycles while held.
- Without KEYPAD_REPEAT_EN, same hold:
  - A single 1010 only.
- Assert rst_n=0 mid-DEBOUNCE:
  - All outputs immediately return to their reset values.

Source files
------------

// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl
// Row-scanning sequencer for a 4x4 active-low matrix keypad. Columns pass
// through a 2-FF synchronizer. A press is debounced, turned into the 4-bit
// converter key code and offered on a valid/ready handshake. The row is
// frozen from press detection until the key has been stably released.
// Optional feature: define KEYPAD_REPEAT_EN to re-emit the held key every
// REPEAT_CYC cycles. Without it, each debounced press yields exactly one code.
module keypad_scan_ctrl #(
  parameter int SCAN_DIV     = 50000,
  parameter int DEBOUNCE_CYC = 500000,
  parameter int REPEAT_CYC   = 25000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] col_n,
  output logic [3:0] row_n,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ready,
  output logic       overrun
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int DEB_W = $clog2(DEBOUNCE_CYC);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 32'sd1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYC - 32'sd1);

  // Reject configurations too small for the scan/debounce sequencing.
  if (SCAN_DIV < 32'sd4 || DEBOUNCE_CYC < 32'sd2 || REPEAT_CYC < 32'sd2) begin : g_param_check
    $error("keypad_scan_ctrl: parameter below its minimum");
  end

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HELD     = 2'd2
  } state_t;

  // Converter encoding for the key at (row, col), col 0 leftmost.
  function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    case ({row, col})
      4'h0:    code = 4'b1110; // 1
      4'h1:    code = 4'b1101; // 2
      4'h2:    code = 4'b1100; // 3
      4'h3:    code = 4'b0101; // A
      4'h4:    code = 4'b1011; // 4
      4'h5:    code = 4'b1010; // 5
      4'h6:    code = 4'b1001; // 6
      4'h7:    code = 4'b0100; // B
      4'h8:    code = 4'b1000; // 7
      4'h9:    code = 4'b0111; // 8
      4'hA:    code = 4'b0110; // 9
      4'hB:    code = 4'b0011; // C
      4'hC:    code = 4'b0001; // *
      4'hD:    code = 4'b1111; // 0
      4'hE:    code = 4'b0000; // #
      4'hF:    code = 4'b0010; // D
      default: code = 4'b1111;
    endcase
    return code;
  endfunction

  // Index of the lowest-numbered low column (caller guarantees one is low).
  function automatic logic [1:0] first_low(input logic [3:0] cols);
    logic [1:0] idx;
    if (!cols[0]) begin
      idx = 2'd0;
    end else if (!cols[1]) begin
      idx = 2'd1;
    end else if (!cols[2]) begin
      idx = 2'd2;
    end else begin
      idx = 2'd3;
    end
    return idx;
  endfunction

  logic [3:0]       col_meta_r;
  logic [3:0]       col_sync_r;
  state_t           state_r,     state_s;
  logic [1:0]       row_idx_r,   row_idx_s;
  logic [3:0]       row_n_r,     row_n_s;
  logic [DIV_W-1:0] dwell_r,     dwell_s;
  logic [DEB_W-1:0] cnt_r,       cnt_s;
  logic [1:0]       col_idx_r,   col_idx_s;
  logic [3:0]       key_code_r,  key_code_s;
  logic             key_valid_r, key_valid_s;
  logic             overrun_r,   overrun_s;
  logic             col_low_s;
  logic             advance_s;
  logic             emit_s;

`ifdef KEYPAD_REPEAT_EN
  localparam int REP_W = $clog2(REPEAT_CYC);
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYC - 32'sd1);
  logic [REP_W-1:0] rep_r, rep_s;
`endif

  // Next-state, counter and handshake logic for the scan FSM.
  always_comb begin
    state_s     = state_r;
    dwell_s     = dwell_r;
    cnt_s       = cnt_r;
    col_idx_s   = col_idx_r;
    advance_s   = 1'b0;
    emit_s      = 1'b0;
    key_code_s  = key_code_r;
    key_valid_s = key_valid_r;
    overrun_s   = 1'b0;
    col_low_s   = ~col_sync_r[col_idx_r];

    case (state_r)
      ST_SCAN: begin
        if (dwell_r == DIV_LAST) begin
          dwell_s = '0;
          if (col_sync_r != 4'b1111) begin
            // Freeze this row and follow only the lowest low column.
            col_idx_s = first_low(col_sync_r);
            cnt_s     = '0;
            state_s   = ST_DEBOUNCE;
          end else begin
            advance_s = 1'b1;
          end
        end else begin
          dwell_s = dwell_r + DIV_W'(1);
        end
      end
      ST_DEBOUNCE: begin
        if (!col_low_s) begin
          // Bounce: abandon the press and resume scanning on the next row.
          state_s   = ST_SCAN;
          advance_s = 1'b1;
          cnt_s     = '0;
          dwell_s   = '0;
        end else if (cnt_r == DEB_LAST) begin
          emit_s  = 1'b1;
          cnt_s   = '0;
          state_s = ST_HELD;
        end else begin
          cnt_s = cnt_r + DEB_W'(1);
        end
      end
      ST_HELD: begin
        if (col_low_s) begin
          cnt_s = '0;
        end else if (cnt_r == DEB_LAST) begin
          state_s   = ST_SCAN;
          advance_s = 1'b1;
          cnt_s     = '0;
          dwell_s   = '0;
        end else begin
          cnt_s = cnt_r + DEB_W'(1);
        end
      end
      default: begin
        state_s = ST_SCAN;
        cnt_s   = '0;
        dwell_s = '0;
      end
    endcase

`ifdef KEYPAD_REPEAT_EN
    // Repeat timer only runs while the latched key is held down in HELD.
    if (state_r != ST_HELD) begin
      rep_s = '0;
    end else if (!col_low_s) begin
      rep_s = '0;
    end else if (rep_r == REP_LAST) begin
      rep_s  = '0;
      emit_s = 1'b1;
    end else begin
      rep_s = rep_r + REP_W'(1);
    end
`endif

    if (advance_s) begin
      row_idx_s = row_idx_r + 2'd1;
    end else begin
      row_idx_s = row_idx_r;
    end
    row_n_s = ~(4'b0001 << row_idx_s);

    // A transfer on the same edge frees the slot, so the new code still loads.
    if (emit_s && (!key_valid_r || key_ready)) begin
      key_code_s  = key_map(row_idx_r, col_idx_r);
      key_valid_s = 1'b1;
    end else if (emit_s) begin
      overrun_s = 1'b1;
    end else if (key_valid_r && key_ready) begin
      key_valid_s = 1'b0;
    end else begin
      key_valid_s = key_valid_r;
    end
  end

  // State, counters, synchronizer and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_meta_r  <= 4'b1111;
      col_sync_r  <= 4'b1111;
      state_r     <= ST_SCAN;
      row_idx_r   <= 2'd0;
      row_n_r     <= 4'b1110;
      dwell_r     <= '0;
      cnt_r       <= '0;
      col_idx_r   <= 2'd0;
      key_code_r  <= 4'b1111;
      key_valid_r <= 1'b0;
      overrun_r   <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rep_r       <= '0;
`endif
    end else begin
      col_meta_r  <= col_n;
      col_sync_r  <= col_meta_r;
      state_r     <= state_s;
      row_idx_r   <= row_idx_s;
      row_n_r     <= row_n_s;
      dwell_r     <= dwell_s;
      cnt_r       <= cnt_s;
      col_idx_r   <= col_idx_s;
      key_code_r  <= key_code_s;
      key_valid_r <= key_valid_s;
      overrun_r   <= overrun_s;
`ifdef KEYPAD_REPEAT_EN
      rep_r       <= rep_s;
`endif
    end
  end

  assign row_n     = row_n_r;
  assign key_code  = key_code_r;
  assign key_valid = key_valid_r;
  assign overrun   = overrun_r;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Bench for keypad_scan_ctrl with a behavioural 4x4 key matrix.
// Expected key codes are queued when a press is made and compared when
// the DUT hands them over on valid/ready.
module tb_keypad_scan_ctrl;

  localparam int SCAN_DIV     = 4;
  localparam int DEBOUNCE_CYC = 8;
  localparam int REPEAT_CYC   = 32;
  // Row start to key_valid: dwell to the sampling cycle, then debounce.
  localparam int PRESS_LAT    = SCAN_DIV + DEBOUNCE_CYC;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] col_n;
  logic [3:0] row_n;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_ready = 1'b0;
  logic       overrun;

  logic [15:0] keys = 16'h0000;    // bit r*4+c set = key at row r, col c pressed
  logic [3:0]  exp_q[$];
  logic [3:0]  exp_code;
  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          ovr_cnt = 0;
  int          exp_ovr = 0;
  int          xfer_cnt = 0;

  keypad_scan_ctrl #(
    .SCAN_DIV    (SCAN_DIV),
    .DEBOUNCE_CYC(DEBOUNCE_CYC),
    .REPEAT_CYC  (REPEAT_CYC)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .col_n    (col_n),
    .row_n    (row_n),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_ready(key_ready),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  // Edge counter used for latency measurements.
  always @(posedge clk) cyc <= cyc + 1;

  // Key matrix: a pressed key pulls its column low while its row is driven.
  always_comb begin
    col_n = 4'b1111;
    for (int r = 0; r < 4; r++) begin
      if (!row_n[r]) col_n = col_n & ~keys[r*4 +: 4];
    end
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Scoreboard side: count overruns and compare every handed-over code.
  always @(negedge clk) begin
    if (rst_n) begin
      if (overrun) ovr_cnt++;
      if (key_valid && key_ready) begin
        xfer_cnt++;
        check_val("xfer_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          exp_code = exp_q.pop_front();
          check_val("xfer_code", key_code, exp_code);
        end
      end
    end
  end

  task automatic wait_row(input logic [3:0] want, output int t);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 80 && !found; i++) begin
      @(negedge clk);
      if (row_n == want) found = 1'b1;
    end
    t = cyc;
    check_val("row_reached", found, 1);
  endtask

  // Press cols of row r just before that row is scanned; measure the result.
  task automatic press_measure(input int r, input logic [3:0] cols,
                               input logic [3:0] code, input bit load);
    int         t0;
    bit         seen;
    string      tag;
    logic [3:0] prev_row;
    logic [3:0] tgt_row;
    prev_row = 4'b1111;
    prev_row[(r + 3) % 4] = 1'b0;
    tgt_row = 4'b1111;
    tgt_row[r] = 1'b0;
    wait_row(prev_row, t0);
    @(posedge clk); #2;
    keys[r*4 +: 4] = cols;
    wait_row(tgt_row, t0);
    if (load) begin
      exp_q.push_back(code);
      tag = "valid_latency";
    end else begin
      exp_ovr++;
      tag = "overrun_latency";
    end
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      seen = load ? key_valid : overrun;
    end
    check_val(tag, cyc - t0, PRESS_LAT);
    check_val("key_code", key_code, code);
    check_val("key_valid_high", key_valid, 1);
    check_val("row_frozen", row_n, tgt_row);
  endtask

  task automatic accept();
    @(posedge clk); #2; key_ready = 1'b1;
    @(posedge clk); #2; key_ready = 1'b0;
    @(negedge clk);
    check_val("valid_cleared", key_valid, 0);
  endtask

  task automatic release_keys();
    @(posedge clk); #2; keys = 16'h0000;
    repeat (20) @(posedge clk);
    #2;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         t0;
    int         x0;
    logic [3:0] er;

    // Reset values
    repeat (3) @(negedge clk);
    check_val("rst_row_n", row_n, 4'b1110);
    check_val("rst_key_code", key_code, 4'b1111);
    check_val("rst_key_valid", key_valid, 0);
    check_val("rst_overrun", overrun, 0);
    rst_n = 1'b1;

    // Idle scanning: one row step every SCAN_DIV edges
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      er = 4'b1111;
      er[(k / SCAN_DIV) % 4] = 1'b0;
      check_val("idle_row", row_n, er);
      check_val("idle_valid_ovr", {key_valid, overrun}, 2'b00);
    end

    // "6" held with key_ready low, then accepted
    press_measure(1, 4'b0100, 4'b1001, 1'b1);
    accept();
    release_keys();

    // "0" bounces: low for 3 debounce cycles, then high
    wait_row(4'b1011, t0);
    @(posedge clk); #2; keys[13] = 1'b1;
    wait_row(4'b0111, t0);
    repeat (5) @(posedge clk);
    #2; keys = 16'h0000;
    repeat (3) @(negedge clk);
    check_val("bounce_frozen", row_n, 4'b0111);
    @(negedge clk);
    check_val("bounce_resume", row_n, 4'b1110);
    check_val("bounce_no_valid", key_valid, 0);
    press_measure(3, 4'b0010, 4'b1111, 1'b1);
    accept();
    release_keys();

    // "A" pending, "#" dropped with overrun, then "#" after acceptance
    press_measure(0, 4'b1000, 4'b0101, 1'b1);
    release_keys();
    press_measure(3, 4'b0100, 4'b0101, 1'b0);
    release_keys();
    accept();
    press_measure(3, 4'b0100, 4'b0000, 1'b1);
    accept();
    release_keys();

    // Two columns in row 0: lowest column wins
    press_measure(0, 4'b1001, 4'b1110, 1'b1);
    accept();
    release_keys();

    // "5" held with key_ready high
    x0 = xfer_cnt;
    @(posedge clk); #2; key_ready = 1'b1;
    press_measure(1, 4'b0010, 4'b1010, 1'b1);
`ifdef KEYPAD_REPEAT_EN
    exp_q.push_back(4'b1010);
    exp_q.push_back(4'b1010);
`endif
    repeat (80) @(posedge clk);
    release_keys();
    key_ready = 1'b0;
`ifdef KEYPAD_REPEAT_EN
    check_val("hold_transfers", xfer_cnt - x0, 3);
`else
    check_val("hold_transfers", xfer_cnt - x0, 1);
`endif
    check_val("queue_empty", exp_q.size(), 0);

    // Reset asserted mid-DEBOUNCE with a code pending
    press_measure(1, 4'b0001, 4'b1011, 1'b1);
    release_keys();
    wait_row(4'b1101, t0);
    @(posedge clk); #2; keys[10] = 1'b1;
    wait_row(4'b1011, t0);
    repeat (SCAN_DIV + 2) @(posedge clk);
    #1;
    check_val("pre_rst_row", row_n, 4'b1011);
    check_val("pre_rst_valid", key_valid, 1);
    #1; rst_n = 1'b0;
    #1;
    check_val("mid_rst_row_n", row_n, 4'b1110);
    check_val("mid_rst_key_code", key_code, 4'b1111);
    check_val("mid_rst_key_valid", key_valid, 0);
    check_val("mid_rst_overrun", overrun, 0);
    exp_q.delete();
    keys = 16'h0000;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check_val("post_rst_valid", key_valid, 0);
    check_val("overrun_total", ovr_cnt, exp_ovr);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
